// File: rtl/vram_arbiter.sv
// Arbitrates RAM port b between VGA reads, a queued CPU write path and CPU reads.
// Latency: ack in T, RAM address/enable registered into T+1, read data returned at T+2+RD_LATENCY.
// Backpressure: the write queue drops wr_ready when full; read requesters hold req until acked.
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VGA  = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              ram_wren_q;
    logic [1:0]        tag_q [RD_LATENCY+1];
    logic [1:0]        tag_d;
    logic              vga_rvalid_q, rd_rvalid_q;
    logic [DATA_W-1:0] vga_rdata_q, rd_rdata_q;

    logic q_empty, push, pop;
    logic win_force, win_vga, win_wr, win_rd;

    assign q_empty  = (count_q == '0);
    assign wr_ready = !clear && (count_q != CNT_FULL);
    assign push     = wr_valid && wr_ready;

    // A CPU read waits for both queued and same-cycle writes so it never overtakes one.
    assign win_force = !clear && !q_empty && (starve_q == STV_MAX);
    assign win_vga   = !clear && !win_force && vga_req;
    assign win_wr    = !clear && !q_empty && (win_force || !vga_req);
    assign win_rd    = !clear && !vga_req && q_empty && !push && rd_req;
    assign pop       = win_wr;

    assign vga_ack    = win_vga;
    assign rd_ack     = win_rd;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_wren   = ram_wren_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;
    assign rd_rvalid  = rd_rvalid_q;
    assign rd_rdata   = rd_rdata_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (q_empty || win_wr) begin
            starve_d = '0;
        end else if (win_vga && (starve_q != STV_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (win_vga) begin
            tag_d = TAG_VGA;
        end else if (win_rd) begin
            tag_d = TAG_CPU;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_wren_q   <= 1'b0;
            vga_rvalid_q <= 1'b0;
            rd_rvalid_q  <= 1'b0;
            vga_rdata_q  <= '0;
            rd_rdata_q   <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end

            if (win_wr) begin
                ram_addr_q <= fifo_addr_q[rptr_q];
                ram_data_q <= fifo_data_q[rptr_q];
                ram_wren_q <= 1'b1;
            end else if (win_vga) begin
                ram_addr_q <= vga_addr;
                ram_wren_q <= 1'b0;
            end else if (win_rd) begin
                ram_addr_q <= rd_addr;
                ram_wren_q <= 1'b0;
            end else begin
                ram_wren_q <= 1'b0;
            end

            // The last tag stage lines up with ram_q being valid for that read.
            tag_q[0] <= tag_d;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            vga_rvalid_q <= (tag_q[RD_LATENCY] == TAG_VGA);
            rd_rvalid_q  <= (tag_q[RD_LATENCY] == TAG_CPU);
            if (tag_q[RD_LATENCY] == TAG_VGA) begin
                vga_rdata_q <= ram_q;
            end
            if (tag_q[RD_LATENCY] == TAG_CPU) begin
                rd_rdata_q <= ram_q;
            end
        end
    end

endmodule
